// File: rtl/fp_add_issue_arbiter_pkg.sv
// Shared definitions for the FP add/sub issue arbiter slice.
//   FP32_W            : IEEE-754 single-precision word width
//   FP32_QNAN/PINF    : canonical special encodings produced by the pipeline
//   fp_op_e           : operation encoding on req_op / pipe_op
//   clog2()           : width of a requester id
package fp_add_issue_arbiter_pkg;

  localparam int unsigned FP32_W = 32;

  localparam logic [FP32_W-1:0] FP32_QNAN = 32'h7FC0_0000;
  localparam logic [FP32_W-1:0] FP32_PINF = 32'h7F80_0000;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } fp_op_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/fp_add_issue_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   eligible : per-index request-eligible bits
//   pointer  : index with highest priority this cycle
//   grant    : one-hot winner (all 0 when nothing is eligible)
//   index    : encoded winner (0 when nothing is eligible)
module rr_arbiter
  import fp_add_issue_arbiter_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] pointer,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IW'((32'(pointer) + k) % N);
      if (!found && eligible[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        index       = cand;
      end
    end
  end

endmodule

// File: rtl/fp_add_issue_arbiter.sv
// fp_add_issue_arbiter: shares one fixed-latency FP add/sub pipeline among
// NUM_REQ requesters with round-robin issue and id-tagged response routing.
//   clk, rst            : clock, asynchronous active-high reset
//   req_valid/req_ready : per-requester handshake (ready is one-hot grant)
//   req_a, req_b, req_op: packed per-requester operands, 32 bits each
//   pipe_issue/a/b/op   : registered issue into the pipeline
//   pipe_result         : pipeline output, valid PIPE_LAT cycles after issue
//   rsp_valid, rsp_data : registered one-hot result strobe and result word
//   busy                : any op in issue, pipeline or response register
// Optional (macro FP_ARB_PERF_EN): perf_clr input, perf_grants output
// carrying saturating 16-bit per-requester grant counters.
module fp_add_issue_arbiter
  import fp_add_issue_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned PIPE_LAT = 5,
  parameter int unsigned MAX_OUT  = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [FP32_W*NUM_REQ-1:0]   req_a,
  input  logic [FP32_W*NUM_REQ-1:0]   req_b,
  input  logic [NUM_REQ-1:0]          req_op,
  output logic                        pipe_issue,
  output logic [FP32_W-1:0]           pipe_a,
  output logic [FP32_W-1:0]           pipe_b,
  output logic                        pipe_op,
  input  logic [FP32_W-1:0]           pipe_result,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [FP32_W-1:0]           rsp_data,
  output logic                        busy
`ifdef FP_ARB_PERF_EN
  ,
  input  logic                        perf_clr,
  output logic [16*NUM_REQ-1:0]       perf_grants
`endif
);

  localparam int unsigned IW   = clog2(NUM_REQ);
  localparam int unsigned CW   = clog2(MAX_OUT + 1);
  localparam int unsigned LAST = PIPE_LAT - 1;

  logic [IW-1:0]       ptr;
  logic [IW-1:0]       win;
  logic [IW-1:0]       issue_id;
  logic [NUM_REQ-1:0]  eligible;
  logic [NUM_REQ-1:0]  grant;
  logic                any_grant;
  logic [CW-1:0]       outstanding [NUM_REQ];
  logic [FP32_W-1:0]   a_arr [NUM_REQ];
  logic [FP32_W-1:0]   b_arr [NUM_REQ];
  logic [PIPE_LAT-1:0] tag_v;
  logic [IW-1:0]       tag_id [PIPE_LAT];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[FP32_W*g +: FP32_W];
    assign b_arr[g] = req_b[FP32_W*g +: FP32_W];
  end

  // A requester at its limit is still eligible in the cycle its response
  // retires an op, so a throttled requester regrants on that same cycle.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i] &
                    ((outstanding[i] < CW'(MAX_OUT)) | rsp_valid[i]);
    end
  end

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .eligible (eligible),
    .pointer  (ptr),
    .grant    (grant),
    .index    (win)
  );

  assign req_ready = grant;
  assign any_grant = |grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_issue <= 1'b0;
      pipe_a     <= '0;
      pipe_b     <= '0;
      pipe_op    <= 1'b0;
      issue_id   <= '0;
      ptr        <= '0;
    end else begin
      pipe_issue <= any_grant;
      if (any_grant) begin
        pipe_a   <= a_arr[win];
        pipe_b   <= b_arr[win];
        pipe_op  <= req_op[win];
        issue_id <= win;
        ptr      <= (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v <= '0;
      for (int unsigned k = 0; k < PIPE_LAT; k++) tag_id[k] <= '0;
    end else begin
      tag_v[0]  <= pipe_issue;
      tag_id[0] <= issue_id;
      for (int unsigned k = 1; k < PIPE_LAT; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= '0;
      if (tag_v[LAST]) begin
        rsp_valid[tag_id[LAST]] <= 1'b1;
        rsp_data                <= pipe_result;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) outstanding[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (grant[i] && !rsp_valid[i])      outstanding[i] <= outstanding[i] + 1'b1;
        else if (!grant[i] && rsp_valid[i]) outstanding[i] <= outstanding[i] - 1'b1;
      end
    end
  end

  assign busy = (|tag_v) | pipe_issue | (|rsp_valid);

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_chk
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(grant[g] && !rsp_valid[g] && outstanding[g] == CW'(MAX_OUT)));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
      !(rsp_valid[g] && !grant[g] && outstanding[g] == '0));
  end

`ifdef FP_ARB_PERF_EN
  logic [15:0] perf_cnt [NUM_REQ];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) perf_cnt[i] <= '0;
    end else if (perf_clr) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) perf_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (grant[i] && perf_cnt[i] != '1) perf_cnt[i] <= perf_cnt[i] + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf
    assign perf_grants[16*g +: 16] = perf_cnt[g];
  end
`endif

endmodule

// File: tb/tb_fp_add_issue_arbiter.sv
module tb_fp_add_issue_arbiter;
  import fp_add_issue_arbiter_pkg::*;

  localparam int unsigned NUM_REQ  = 4;
  localparam int unsigned PIPE_LAT = 5;
  localparam int unsigned MAX_OUT  = 3;
  localparam int          RLAT     = PIPE_LAT + 2;

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [32*NUM_REQ-1:0]     req_a;
  logic [32*NUM_REQ-1:0]     req_b;
  logic [NUM_REQ-1:0]        req_op;
  logic                      pipe_issue;
  logic [31:0]               pipe_a;
  logic [31:0]               pipe_b;
  logic                      pipe_op;
  logic [31:0]               pipe_result;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [31:0]               rsp_data;
  logic                      busy;
`ifdef FP_ARB_PERF_EN
  logic                      perf_clr;
  logic [16*NUM_REQ-1:0]     perf_grants;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;

  fp_add_issue_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .PIPE_LAT (PIPE_LAT),
    .MAX_OUT  (MAX_OUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
    .pipe_issue  (pipe_issue),
    .pipe_a      (pipe_a),
    .pipe_b      (pipe_b),
    .pipe_op     (pipe_op),
    .pipe_result (pipe_result),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .busy        (busy)
`ifdef FP_ARB_PERF_EN
    ,
    .perf_clr    (perf_clr),
    .perf_grants (perf_grants)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed FP results for the operand pairs used below.
  function automatic logic [31:0] fp_ref(input logic [31:0] a, input logic [31:0] b,
                                         input logic op);
    case ({op, a, b})
      {OP_ADD, 32'h3F80_0000, 32'h4000_0000}: return 32'h4040_0000;
      {OP_ADD, 32'h3F80_0000, 32'h3F80_0000}: return 32'h4000_0000;
      {OP_ADD, 32'h3F80_0000, 32'h4040_0000}: return 32'h4080_0000;
      {OP_ADD, 32'h3F80_0000, 32'h4080_0000}: return 32'h40A0_0000;
      {OP_ADD, 32'h4000_0000, 32'h4000_0000}: return 32'h4080_0000;
      {OP_SUB, FP32_PINF,     FP32_PINF    }: return FP32_QNAN;
      default:                                return a ^ b ^ 32'h5A5A_5A5A;
    endcase
  endfunction

  // Fixed-latency pipeline stand-in: result appears PIPE_LAT cycles after issue.
  logic [31:0] pipe_stage [PIPE_LAT];
  always @(posedge clk) begin
    pipe_stage[0] <= pipe_issue ? fp_ref(pipe_a, pipe_b, pipe_op) : 32'hDEAD_BEEF;
    for (int k = 1; k < PIPE_LAT; k++) pipe_stage[k] <= pipe_stage[k-1];
  end
  assign pipe_result = pipe_stage[PIPE_LAT-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic op);
    req_a[32*id +: 32] = a;
    req_b[32*id +: 32] = b;
    req_op[id]         = op;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
`ifdef FP_ARB_PERF_EN
    perf_clr  = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"},     32'(req_ready),  32'h0);
    check({tag, "_issue"},     32'(pipe_issue), 32'h0);
    check({tag, "_pipe_a"},    pipe_a,          32'h0);
    check({tag, "_pipe_b"},    pipe_b,          32'h0);
    check({tag, "_pipe_op"},   32'(pipe_op),    32'h0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid),  32'h0);
    check({tag, "_rsp_data"},  rsp_data,        32'h0);
    check({tag, "_busy"},      32'(busy),       32'h0);
  endtask

  // One op from one requester; handshake in cycle 0, response in cycle RLAT.
  task automatic single_op(input string name, input int id, input logic [31:0] a,
                           input logic [31:0] b, input logic op, input logic [31:0] exp);
    logic [NUM_REQ-1:0] oh;
    oh = NUM_REQ'(1) << id;
    @(negedge clk);
    set_req(id, a, b, op);
    req_valid = oh;
    for (int k = 0; k <= RLAT + 1; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 1) req_valid = '0;
      #1;
      if (k == 0) check({name, "_ready"}, 32'(req_ready), 32'(oh));
      if (k == 1) begin
        check({name, "_issue"},   32'(pipe_issue), 32'h1);
        check({name, "_pipe_a"},  pipe_a,          a);
        check({name, "_pipe_b"},  pipe_b,          b);
        check({name, "_pipe_op"}, 32'(pipe_op),    32'(op));
      end
      check({name, "_rsp_valid"}, 32'(rsp_valid), (k == RLAT) ? 32'(oh) : 32'h0);
      if (k == RLAT) check({name, "_rsp_data"}, rsp_data, exp);
    end
  endtask

  logic [31:0] rr_b   [4] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
  logic [31:0] rr_exp [4] = '{32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
`ifdef FP_ARB_PERF_EN
    perf_clr  = 1'b0;
`endif
    #1;
    check_all_zero("in_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("after_reset");

    // Single add, exact latency.
    single_op("add1p2", 0, 32'h3F80_0000, 32'h4000_0000, OP_ADD, 32'h4040_0000);

    // Special case through the pipeline, same latency.
    single_op("inf_sub", 1, FP32_PINF, FP32_PINF, OP_SUB, FP32_QNAN);

    // All four requesters continuously from pointer 0.
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 4; i++) set_req(i, 32'h3F80_0000, rr_b[i], OP_ADD);
    req_valid = '1;
    for (int k = 0; k <= 15; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 8) req_valid = '0;
      #1;
      check("rr_ready", 32'(req_ready), (k < 8) ? (32'h1 << (k % 4)) : 32'h0);
      check("rr_issue", 32'(pipe_issue), (k >= 1 && k <= 8) ? 32'h1 : 32'h0);
      if (k >= 1 && k <= 8) check("rr_pipe_b", pipe_b, rr_b[(k-1) % 4]);
      if (k >= RLAT && k < RLAT + 8) begin
        check("rr_rsp_valid", 32'(rsp_valid), 32'h1 << ((k - RLAT) % 4));
        check("rr_rsp_data",  rsp_data,       rr_exp[(k - RLAT) % 4]);
      end else begin
        check("rr_rsp_valid", 32'(rsp_valid), 32'h0);
      end
    end

    // Requester 2 alone, throttled by MAX_OUT, regrant on its response.
    do_reset();
    @(negedge clk);
    set_req(2, 32'h4000_0000, 32'h4000_0000, OP_ADD);
    req_valid = 4'b0100;
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      check("thr_ready", 32'(req_ready),
            (k < int'(MAX_OUT) || (k >= RLAT && k < RLAT + 3)) ? 32'h4 : 32'h0);
      check("thr_rsp_valid", 32'(rsp_valid),
            (k >= RLAT && k < RLAT + 3) ? 32'h4 : 32'h0);
      if (k >= RLAT && k < RLAT + 3) check("thr_rsp_data", rsp_data, 32'h4080_0000);
    end
    req_valid = '0;

    // Reset with four ops in flight.
    do_reset();
    @(negedge clk);
    for (int i = 1; i < 4; i++) set_req(i, 32'h1000_0000 * i, 32'h0000_0100 * i, OP_SUB);
    req_valid = 4'b1110;
    repeat (4) @(negedge clk);
    req_valid = '0;
    #1;
    check("flight_busy", 32'(busy), 32'h1);
    check("flight_issue", 32'(pipe_issue), 32'h1);
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      #1;
      check("post_rst_rsp", 32'(rsp_valid), 32'h0);
      check("post_rst_busy", 32'(busy), 32'h0);
    end
    req_valid = '1;
    #1;
    check("post_rst_ptr0", 32'(req_ready), 32'h1);
    req_valid = '0;

`ifdef FP_ARB_PERF_EN
    begin
      int  g;
      bit  hit;
      do_reset();
      @(negedge clk);
      set_req(3, 32'h3F80_0000, 32'h4000_0000, OP_ADD);
      req_valid = 4'b1000;
      g = 0;
      for (int c = 0; c < 200 && g < 10; c++) begin
        if (c > 0) @(negedge clk);
        #1;
        if (req_ready[3]) g++;
      end
      check("perf_grants_seen", 32'(g), 32'd10);
      @(posedge clk);
      #1;
      req_valid = '0;
      @(negedge clk);
      #1;
      check("perf_cnt10", 32'(perf_grants[48 +: 16]), 32'd10);
      check("perf_other", 32'(perf_grants[0 +: 48]), 32'h0);
      req_valid = 4'b1000;
      hit = 1'b0;
      for (int c = 0; c < 50 && !hit; c++) begin
        @(negedge clk);
        #1;
        if (req_ready[3]) hit = 1'b1;
      end
      check("perf_clr_grant", 32'(hit), 32'h1);
      check("perf_before_clr", 32'(perf_grants[48 +: 16]), 32'd10);
      perf_clr = 1'b1;
      @(posedge clk);
      #1;
      perf_clr  = 1'b0;
      req_valid = '0;
      @(negedge clk);
      #1;
      check("perf_after_clr", 32'(perf_grants[48 +: 16]), 32'd0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
